// File: rtl/regfile_pkg.sv
// Shared defaults and types for the RV32 general-purpose register file.
package regfile_pkg;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = 5;

  localparam logic [AW_DEF-1:0] ZERO_REG = 5'd0;

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [AW_DEF-1:0]   regaddr_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: x0 forced to zero, optional same-cycle
// write forwarding when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic [NREGS-1:1][XLEN-1:0] regs,
  input  logic [AW-1:0]              rr,
`ifdef REGFILE_BYPASS_EN
  input  logic                       byp_en,
  input  logic [AW-1:0]              wr,
  input  logic [XLEN-1:0]            wd,
`endif
  output logic [XLEN-1:0]            rd
);

  always_comb begin
    rd = '0;
    if (rr != AW'(ZERO_REG)) begin
`ifdef REGFILE_BYPASS_EN
      if (byp_en && (rr == wr)) rd = wd;
      else                      rd = regs[rr];
`else
      rd = regs[rr];
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// 32-entry register file, two async read ports, one sync write port, x0 = 0.
// Optional write-to-read forwarding enabled by defining REGFILE_BYPASS_EN.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   wr,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   rr1,
  input  logic [AW-1:0]   rr2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  // No storage for x0: the array starts at index 1.
  logic [NREGS-1:1][XLEN-1:0] regs;

  always_ff @(posedge clk) begin
    if (!rst_n)                          regs     <= '0;
    else if (we && wr != AW'(ZERO_REG))  regs[wr] <= wd;
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  assign byp_en = rst_n && we && (wr != AW'(ZERO_REG));
`endif

  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rp1 (
    .regs   (regs),
    .rr     (rr1),
`ifdef REGFILE_BYPASS_EN
    .byp_en (byp_en),
    .wr     (wr),
    .wd     (wd),
`endif
    .rd     (rd1)
  );

  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rp2 (
    .regs   (regs),
    .rr     (rr2),
`ifdef REGFILE_BYPASS_EN
    .byp_en (byp_en),
    .wr     (wr),
    .wd     (wd),
`endif
    .rd     (rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read data is queued when a
// read is driven and popped when the combinational output is sampled.
module tb_register_file;
  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [4:0]  rr1;
  logic [4:0]  rr2;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb[$];

  register_file #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wr    (wr),
    .wd    (wd),
    .rr1   (rr1),
    .rr2   (rr2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_rd1"}, rd1, e.e1);
      check({e.tag, "_rd2"}, rd2, e.e2);
    end
  endtask

  task automatic drive_read(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clk);
    rr1 = a1;
    rr2 = a2;
    sb.push_back('{tag, e1, e2});
    #1;
    sample();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge clk);
    we = en;
    wr = a;
    wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    wr    = '0;
    wd    = '0;
    rr1   = '0;
    rr2   = '0;

    // x0 must read zero even before any reset edge
    #1;
    check("x0_pre_reset", rd1, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++)
      drive_read("reset_sweep", 5'(i), 5'(31 - i), 32'h0, 32'h0);

    do_write(5'd10, 32'hdeadbeef, 1'b1);
    drive_read("wr10_a", 5'd10, 5'd11, 32'hdeadbeef, 32'h0);
    drive_read("wr10_b", 5'd0, 5'd10, 32'h0, 32'hdeadbeef);
    drive_read("same_addr", 5'd10, 5'd10, 32'hdeadbeef, 32'hdeadbeef);

    do_write(5'd0, 32'h12345678, 1'b1);
    drive_read("x0_protect", 5'd0, 5'd10, 32'h0, 32'hdeadbeef);

    do_write(5'd20, 32'hfacecafe, 1'b1);
    drive_read("wr20", 5'd20, 5'd10, 32'hfacecafe, 32'hdeadbeef);
    drive_read("wr31_untouched", 5'd31, 5'd1, 32'h0, 32'h0);

    // we=0 across several edges must not change x5
    @(negedge clk);
    we = 1'b0;
    wr = 5'd5;
    wd = 32'h11111111;
    repeat (3) @(posedge clk);
    #1;
    drive_read("we0_x5", 5'd5, 5'd20, 32'h0, 32'hfacecafe);

    // reset wins over a simultaneous write
    @(negedge clk);
    rst_n = 1'b0;
    we    = 1'b1;
    wr    = 5'd5;
    wd    = 32'h11111111;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    we    = 1'b0;
    drive_read("rst_prio", 5'd5, 5'd10, 32'h0, 32'h0);
    drive_read("rst_clear20", 5'd20, 5'd7, 32'h0, 32'h0);

    // same-cycle hazard on x7
    @(negedge clk);
    we  = 1'b1;
    wr  = 5'd7;
    wd  = 32'hA5A5A5A5;
    rr1 = 5'd7;
    rr2 = 5'd0;
`ifdef REGFILE_BYPASS_EN
    sb.push_back('{"hazard_pre", 32'hA5A5A5A5, 32'h0});
`else
    sb.push_back('{"hazard_pre", 32'h0, 32'h0});
`endif
    #1;
    sample();
    @(posedge clk);
    #1;
    we = 1'b0;
    sb.push_back('{"hazard_post", 32'hA5A5A5A5, 32'h0});
    #1;
    sample();

    // a few distinct patterns across both ports
    do_write(5'd1, 32'h00000001, 1'b1);
    do_write(5'd31, 32'h80000000, 1'b1);
    drive_read("edge_regs", 5'd1, 5'd31, 32'h00000001, 32'h80000000);
    drive_read("edge_regs_swap", 5'd31, 5'd7, 32'h80000000, 32'hA5A5A5A5);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
